// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone-style arbiter in front of one memory slave.
// Master 0 is instruction fetch, master 1 is load/store. One transaction is
// outstanding at a time. Requests go to the slave combinationally, and the
// slave ack is returned to the owner combinationally. A watchdog ends a
// transaction with an error if the slave never acks.
//
//   state  | meaning
//   S_IDLE | arbitrate and forward the granted request; leave on acceptance
//   S_WAIT | waiting for slave ack or terminal count; no new request taken
module wb_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic [2:0]  i_m0_sel,
  output logic        o_m0_ack,
  output logic        o_m0_stall,
  output logic        o_m0_err,
  output logic [31:0] o_m0_data,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic [2:0]  i_m1_sel,
  output logic        o_m1_ack,
  output logic        o_m1_stall,
  output logic        o_m1_err,
  output logic [31:0] o_m1_data,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_data,
  output logic [2:0]  o_s_sel,
  input  logic        i_s_ack,
  input  logic        i_s_stall,
  input  logic [31:0] i_s_data
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] TC = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic       r_owner;
  logic       r_last_owner;
  logic [7:0] r_count;

  logic        w_idle;
  logic        w_wait;
  logic        w_grant;
  logic        w_gidx;
  logic        w_accept;
  logic        w_tc;
  logic        w_done;
  logic        w_err;
  logic [31:0] w_rdata;

  // Outputs are forced quiet while reset is asserted, independent of state.
  assign w_idle = (r_state == S_IDLE) && !i_reset;
  assign w_wait = (r_state == S_WAIT) && !i_reset;

  // Tie goes to the master that did not own the previous transaction.
  assign w_grant  = w_idle && (i_m0_stb || i_m1_stb);
  assign w_gidx   = (i_m0_stb && i_m1_stb) ? ~r_last_owner : i_m1_stb;
  assign w_accept = w_grant && !i_s_stall;

  // Slave ack wins over terminal count on the same cycle.
  assign w_tc    = (r_count == TC);
  assign w_done  = w_wait && (i_s_ack || w_tc);
  assign w_err   = w_done && !i_s_ack;
  assign w_rdata = w_err ? 32'hFFFF_FFFF : i_s_data;

  // Forward the granted request to the slave, zeros when nothing is granted.
  always_comb begin
    o_s_stb  = w_grant;
    o_s_we   = 1'b0;
    o_s_addr = 32'h0;
    o_s_data = 32'h0;
    o_s_sel  = 3'b000;
    if (w_grant) begin
      o_s_we   = w_gidx ? i_m1_we   : i_m0_we;
      o_s_addr = w_gidx ? i_m1_addr : i_m0_addr;
      o_s_data = w_gidx ? i_m1_data : i_m0_data;
      o_s_sel  = w_gidx ? i_m1_sel  : i_m0_sel;
    end
  end

  // Per-master response: only the owner ever sees ack/err.
  always_comb begin
    o_m0_stall = !(w_accept && !w_gidx);
    o_m1_stall = !(w_accept && w_gidx);
    o_m0_ack   = w_done && !r_owner;
    o_m1_ack   = w_done && r_owner;
    o_m0_err   = o_m0_ack && w_err;
    o_m1_err   = o_m1_ack && w_err;
    o_m0_data  = o_m0_ack ? w_rdata : 32'hFFFF_FFFF;
    o_m1_data  = o_m1_ack ? w_rdata : 32'hFFFF_FFFF;
  end

  // Arbitration state, ownership and watchdog counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_count      <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner      <= w_gidx;
            r_last_owner <= w_gidx;
            r_count      <= 8'd0;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_done) r_state <= S_IDLE;
          else        r_count <= r_count + 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_wb_arbiter;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_stb, m0_we, m1_stb, m1_we;
  logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
  logic [2:0]  m0_sel, m1_sel;
  logic        m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_stb, s_we, s_ack, s_stall;
  logic [31:0] s_addr, s_wdat, s_rdat;
  logic [2:0]  s_sel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_data(m0_data),
    .i_m0_sel(m0_sel), .o_m0_ack(m0_ack), .o_m0_stall(m0_stall), .o_m0_err(m0_err),
    .o_m0_data(m0_rdat),
    .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_data(m1_data),
    .i_m1_sel(m1_sel), .o_m1_ack(m1_ack), .o_m1_stall(m1_stall), .o_m1_err(m1_err),
    .o_m1_data(m1_rdat),
    .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_data(s_wdat),
    .o_s_sel(s_sel), .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data(s_rdat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: either free, or busy with an owner and the
  // 1-based index of the current waiting cycle.
  bit          md_busy;
  bit          md_owner;
  bit          md_last;
  int          md_waited;
  logic [31:0] e_sa, e_sd;
  logic        e_swe, e_sstb;
  logic [2:0]  e_ssel;
  logic [1:0]  e_ack, e_err, e_stall;
  logic [31:0] e_dat [2];
  bit          want, gidx;

  always @(negedge clk) begin : compare
    e_sstb = 0; e_swe = 0; e_sa = 0; e_sd = 0; e_ssel = 0;
    e_ack = 0; e_err = 0; e_stall = 2'b11;
    e_dat[0] = 32'hFFFF_FFFF; e_dat[1] = 32'hFFFF_FFFF;
    if (rst) begin
      md_busy = 0; md_owner = 0; md_last = 1; md_waited = 0;
    end else if (!md_busy) begin
      want = m0_stb || m1_stb;
      gidx = (m0_stb && m1_stb) ? !md_last : m1_stb;
      if (want) begin
        e_sstb = 1;
        e_swe  = gidx ? m1_we   : m0_we;
        e_sa   = gidx ? m1_addr : m0_addr;
        e_sd   = gidx ? m1_data : m0_data;
        e_ssel = gidx ? m1_sel  : m0_sel;
        if (!s_stall) begin
          e_stall[gidx] = 0;
          md_busy = 1; md_owner = gidx; md_last = gidx; md_waited = 1;
        end
      end
    end else begin
      if (s_ack || md_waited == TO) begin
        e_ack[md_owner] = 1;
        e_err[md_owner] = !s_ack;
        e_dat[md_owner] = s_ack ? s_rdat : 32'hFFFF_FFFF;
        md_busy = 0;
      end else begin
        md_waited++;
      end
    end
    check("s_stb", {31'd0, s_stb}, {31'd0, e_sstb});
    check("s_we", {31'd0, s_we}, {31'd0, e_swe});
    check("s_addr", s_addr, e_sa);
    check("s_data", s_wdat, e_sd);
    check("s_sel", {29'd0, s_sel}, {29'd0, e_ssel});
    check("acks", {30'd0, m1_ack, m0_ack}, {30'd0, e_ack});
    check("errs", {30'd0, m1_err, m0_err}, {30'd0, e_err});
    check("stalls", {30'd0, m1_stall, m0_stall}, {30'd0, e_stall});
    check("m0_data", m0_rdat, e_dat[0]);
    check("m1_data", m1_rdat, e_dat[1]);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic quiet();
    m0_stb = 0; m1_stb = 0; s_ack = 0; s_stall = 0;
  endtask

  task automatic reset_pulse();
    nxt(); rst = 1; quiet();
    neg();
    nxt(); rst = 0;
  endtask

  task automatic req(input bit idx, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (idx) begin m1_stb = 1; m1_we = we; m1_addr = a; m1_data = d; m1_sel = 3'b010; end
    else     begin m0_stb = 1; m0_we = we; m0_addr = a; m0_data = d; m0_sel = 3'b010; end
  endtask

  logic [2:0] sels [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  int ack_pct;

  initial begin
    rst = 1; quiet();
    m0_we = 0; m1_we = 0; m0_addr = 0; m1_addr = 0; m0_data = 0; m1_data = 0;
    m0_sel = 0; m1_sel = 0; s_rdat = 0;
    neg();
    check("reset stall0", {31'd0, m0_stall}, 32'd1);
    check("reset stall1", {31'd0, m1_stall}, 32'd1);
    check("reset s_stb", {31'd0, s_stb}, 32'd0);
    nxt(); rst = 0;

    // M0 read, slave acks on the second waiting cycle.
    req(0, 0, 32'h10, 32'h0);
    neg();
    check("m0 issue stall", {31'd0, m0_stall}, 32'd0);
    check("m0 issue addr", s_addr, 32'h10);
    nxt(); quiet();
    neg();
    check("m0 wait1 ack", {31'd0, m0_ack}, 32'd0);
    nxt(); s_ack = 1; s_rdat = 32'h1234_5678;
    neg();
    check("m0 read ack", {31'd0, m0_ack}, 32'd1);
    check("m0 read data", m0_rdat, 32'h1234_5678);
    check("m0 read m1ack", {31'd0, m1_ack}, 32'd0);
    nxt(); quiet();
    neg();
    check("m0 ack one cycle", {31'd0, m0_ack}, 32'd0);

    // Both masters requesting: strict alternation starting with M0.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      req(0, 0, 32'h100, 32'h0); req(1, 1, 32'h200, 32'h5);
      s_ack = 0;
      neg();
      check("alt addr", s_addr, (i % 2 == 1) ? 32'h200 : 32'h100);
      nxt(); s_ack = 1; s_rdat = i;
      neg();
      check("alt ack", {30'd0, m1_ack, m0_ack}, (i % 2 == 1) ? 32'd2 : 32'd1);
      nxt();
    end
    quiet();

    // Slave stall holds the M0 request on the bus without accepting.
    reset_pulse();
    req(0, 0, 32'h100, 32'h0); req(1, 0, 32'h200, 32'h0); s_stall = 1;
    for (int i = 0; i < 3; i++) begin
      neg();
      check("stall s_stb", {31'd0, s_stb}, 32'd1);
      check("stall addr", s_addr, 32'h100);
      check("stall both", {30'd0, m1_stall, m0_stall}, 32'd3);
      nxt();
    end
    s_stall = 0;
    neg();
    check("unstall m0", {31'd0, m0_stall}, 32'd0);
    nxt(); quiet();
    neg();
    check("in wait s_stb", {31'd0, s_stb}, 32'd0);
    nxt(); s_ack = 1;
    neg();
    nxt(); quiet();

    // M1 write with no slave ack: error termination on the 64th wait cycle.
    req(1, 1, 32'h300, 32'hDEAD_BEEF);
    neg();
    nxt(); quiet();
    for (int i = 1; i <= TO; i++) begin
      neg();
      if (i < TO) check("to early ack", {31'd0, m1_ack}, 32'd0);
      else begin
        check("to ack", {31'd0, m1_ack}, 32'd1);
        check("to err", {31'd0, m1_err}, 32'd1);
        check("to data", m1_rdat, 32'hFFFF_FFFF);
      end
      nxt();
    end
    neg();
    check("to back idle", {31'd0, m1_ack}, 32'd0);

    // Ack coincident with terminal count is a normal completion.
    nxt(); req(0, 0, 32'h40, 32'h0);
    neg();
    nxt(); quiet();
    for (int i = 1; i <= TO; i++) begin
      if (i == TO) begin s_ack = 1; s_rdat = 32'hA5A5_A5A5; end
      neg();
      if (i == TO) begin
        check("tc ack", {31'd0, m0_ack}, 32'd1);
        check("tc err", {31'd0, m0_err}, 32'd0);
        check("tc data", m0_rdat, 32'hA5A5_A5A5);
      end
      nxt();
    end
    quiet();

    // Reset while waiting abandons the transaction; a late ack is ignored.
    req(1, 0, 32'h80, 32'h0);
    neg();
    nxt(); quiet();
    neg();
    nxt(); rst = 1;
    neg();
    check("rst s_stb", {31'd0, s_stb}, 32'd0);
    check("rst acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    nxt(); rst = 0; s_ack = 1; s_rdat = 32'h1111_2222;
    neg();
    check("stray ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    nxt(); quiet();

    // Randomized traffic with varying slave responsiveness.
    for (int seg = 0; seg < 6; seg++) begin
      ack_pct = (seg % 3 == 0) ? 50 : ((seg % 3 == 1) ? 2 : 15);
      for (int c = 0; c < 500; c++) begin
        rst     = ($urandom_range(999) < 3);
        m0_stb  = ($urandom_range(99) < 60);
        m1_stb  = ($urandom_range(99) < 60);
        m0_we   = $urandom_range(1);
        m1_we   = $urandom_range(1);
        m0_addr = $urandom; m1_addr = $urandom;
        m0_data = $urandom; m1_data = $urandom;
        m0_sel  = sels[$urandom_range(4)];
        m1_sel  = sels[$urandom_range(4)];
        s_stall = ($urandom_range(99) < 30);
        s_ack   = ($urandom_range(99) < ack_pct);
        s_rdat  = $urandom;
        neg();
        nxt();
      end
    end
    rst = 0; quiet();
    neg();
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
